// File: rtl/ntt_pkg.sv
// ntt_pkg: shared frame size, bit-reversal helper and read FSM encoding for the NTT input loader
package ntt_pkg;
  localparam int RING_SIZE = 256;
  localparam int LOG_N = $clog2(RING_SIZE);
  typedef enum logic [1:0] {IDLE, FETCH, STREAM} rd_state_e;
  function automatic logic [15:0] bitrev(input logic [15:0] idx, input int lg = LOG_N);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < lg; i++) r[lg-1-i] = idx[i];
    return r;
  endfunction
endpackage

// File: rtl/ntt_coef_bank.sv
// ntt_coef_bank: one coefficient RAM bank (clk/reset; we_i/waddr_i/wdata_i write port; re_i/pair_i read of words 2k,2k+1 into registered a_o/b_o)
module ntt_coef_bank #(
  parameter int DEPTH = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-2:0]   pair_i,
  output logic [DATA_WIDTH-1:0]      a_o,
  output logic [DATA_WIDTH-1:0]      b_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] a_q, b_q;
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (re_i) begin
      a_q <= mem_q[{pair_i, 1'b0}];
      b_q <= mem_q[{pair_i, 1'b1}];
    end
  end
  assign a_o = a_q;
  assign b_o = b_q;
endmodule

// File: rtl/ntt_bitrev_loader.sv
// ntt_bitrev_loader: natural-order coefficient stream in (in_*), bit-reversed ping-pong storage, butterfly pairs out (out_*) with controller start level
module ntt_bitrev_loader #(
  parameter int RING_SIZE = ntt_pkg::RING_SIZE,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  out_last,
  output logic                  start
);
  import ntt_pkg::*;
  localparam int LG = $clog2(RING_SIZE);
  localparam int HALF = RING_SIZE / 2;
  rd_state_e state_q, state_d;
  logic [LG-1:0] wr_idx_q, wr_idx_d, waddr;
  logic [LG-2:0] k_q, k_d;
  logic [1:0] full_q, full_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, gap_q, gap_d;
  logic wr_hs, wr_done, rd_hs, rd_done, re;
  logic [DATA_WIDTH-1:0] rd_a [2];
  logic [DATA_WIDTH-1:0] rd_b [2];
  always_comb begin
    in_ready = !reset && !full_q[wr_bank_q];
    wr_hs = in_valid && in_ready;
    wr_done = wr_hs && (&wr_idx_q);
    waddr = LG'(bitrev(16'(wr_idx_q), LG));
    out_valid = state_q == STREAM;
    out_last = out_valid && k_q == (LG-1)'(HALF-1);
    rd_hs = out_valid && out_ready;
    rd_done = rd_hs && out_last;
    re = state_q == FETCH;
    start = state_q != IDLE && !gap_q;
    out_a = rd_a[rd_bank_q];
    out_b = rd_b[rd_bank_q];
    wr_idx_d = wr_hs ? wr_idx_q + LG'(1) : wr_idx_q;
    wr_bank_d = wr_bank_q ^ wr_done;
    rd_bank_d = rd_bank_q ^ rd_done;
    k_d = rd_done ? '0 : rd_hs ? k_q + (LG-1)'(1) : k_q;
    gap_d = rd_done;
    full_d = full_q;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    state_d = state_q == IDLE ? (full_q[rd_bank_q] ? FETCH : IDLE) :
              state_q == FETCH ? STREAM :
              !rd_hs ? STREAM :
              !rd_done ? FETCH :
              full_q[~rd_bank_q] ? FETCH : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_idx_q <= '0;
      k_q <= '0;
      full_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      gap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_idx_q <= wr_idx_d;
      k_q <= k_d;
      full_q <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      gap_q <= gap_d;
    end
  end
  for (genvar g = 0; g < 2; g++) begin : g_bank
    ntt_coef_bank #(.DEPTH(RING_SIZE), .DATA_WIDTH(DATA_WIDTH)) u_bank (
      .clk     (clk),
      .reset   (reset),
      .we_i    (wr_hs && wr_bank_q == 1'(g)),
      .waddr_i (waddr),
      .wdata_i (in_data),
      .re_i    (re && rd_bank_q == 1'(g)),
      .pair_i  (k_q),
      .a_o     (rd_a[g]),
      .b_o     (rd_b[g])
    );
  end
endmodule

// File: tb/tb_ntt_bitrev_loader.sv
// tb_ntt_bitrev_loader: directed self-checking bench for the bit-reversing NTT input loader
module tb_ntt_bitrev_loader;
  logic clk = 0, rst = 1, iv = 0, ordy = 0, iv2 = 0, ordy2 = 0;
  logic [31:0] id = 0, id2 = 0;
  logic irdy, ov, ol, st, irdy2, ov2, ol2, st2;
  logic [31:0] oa, ob, oa2, ob2;
  logic [31:0] big [256];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ntt_bitrev_loader #(.RING_SIZE(8), .DATA_WIDTH(32)) d8 (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(irdy), .in_data(id),
    .out_valid(ov), .out_ready(ordy), .out_a(oa), .out_b(ob), .out_last(ol), .start(st));
  ntt_bitrev_loader #(.RING_SIZE(256), .DATA_WIDTH(32)) d256 (
    .clk(clk), .reset(rst), .in_valid(iv2), .in_ready(irdy2), .in_data(id2),
    .out_valid(ov2), .out_ready(ordy2), .out_a(oa2), .out_b(ob2), .out_last(ol2), .start(st2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic logic [7:0] br8(input logic [7:0] x);
    logic [7:0] r;
    r = {<<{x}};
    return r;
  endfunction
  task automatic send(input int b0, input int nf, input bit nowait);
    for (int f = 0; f < nf; f++)
      for (int i = 0; i < 8; i++) begin
        iv = 1;
        id = 32'(b0 + 10 * f + i);
        for (int t = 0; t < 40 && !nowait && !irdy; t++) step;
        chk("in_ready", 32'(irdy), 1);
        step;
      end
    iv = 0;
  endtask
  task automatic drain(input int b0, input int hold_k, input int np);
    int ea[4];
    int eb[4];
    ea = '{0, 2, 1, 3};
    eb = '{4, 6, 5, 7};
    for (int k = 0; k < np; k++) begin
      ordy = 1;
      for (int t = 0; t < 20 && !ov; t++) step;
      chk("out_valid", 32'(ov), 1);
      chk("out_a", oa, 32'(b0 + ea[k]));
      chk("out_b", ob, 32'(b0 + eb[k]));
      chk("out_last", 32'(ol), 32'(k == 3));
      chk("start", 32'(st), 1);
      if (k == hold_k) begin
        ordy = 0;
        repeat (5) begin
          step;
          chk("hold_valid", 32'(ov), 1);
          chk("hold_a", oa, 32'(b0 + ea[k]));
          chk("hold_b", ob, 32'(b0 + eb[k]));
        end
        ordy = 1;
      end
      step;
      if (k < 3) chk("bubble", 32'(ov), 0);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    rst = 1;
    step;
    step;
    chk("rst_in_ready", 32'(irdy), 0);
    chk("rst_out_valid", 32'(ov), 0);
    chk("rst_start", 32'(st), 0);
    chk("rst_out_last", 32'(ol), 0);
    chk("rst_out_a", oa, 0);
    chk("rst_out_b", ob, 0);
    chk("rst_in_ready_256", 32'(irdy2), 0);
    rst = 0;
    #1;
    chk("in_ready_after_reset", 32'(irdy), 1);
    // single frame and latency
    send(0, 1, 1);
    chk("lat1_valid", 32'(ov), 0);
    step;
    chk("lat2_valid", 32'(ov), 0);
    chk("fetch_start", 32'(st), 1);
    step;
    chk("lat_first_valid", 32'(ov), 1);
    drain(0, -1, 4);
    chk("idle_start", 32'(st), 0);
    chk("idle_valid", 32'(ov), 0);
    // back-to-back frames
    fork
      send(0, 2, 1);
      begin
        drain(0, -1, 4);
        chk("start_gap", 32'(st), 0);
        step;
        chk("start_regain", 32'(st), 1);
        drain(10, -1, 4);
      end
    join
    // backpressure on pair 1
    send(0, 1, 1);
    drain(0, 1, 4);
    // both banks full
    ordy = 0;
    send(0, 2, 1);
    chk("both_full_ready", 32'(irdy), 0);
    step;
    step;
    chk("both_full_ready_hold", 32'(irdy), 0);
    fork
      send(20, 1, 0);
      begin
        drain(0, -1, 4);
        chk("ready_restored", 32'(irdy), 1);
        drain(10, -1, 4);
        drain(20, -1, 4);
      end
    join
    // reset mid-stream
    send(0, 1, 1);
    drain(0, -1, 2);
    rst = 1;
    step;
    chk("mid_rst_valid", 32'(ov), 0);
    chk("mid_rst_start", 32'(st), 0);
    rst = 0;
    #1;
    chk("mid_rst_in_ready", 32'(irdy), 1);
    send(20, 1, 1);
    drain(20, -1, 4);
    // 256-point frame with random data
    for (int i = 0; i < 256; i++) big[i] = $urandom;
    chk("big_in_ready", 32'(irdy2), 1);
    iv2 = 1;
    for (int i = 0; i < 256; i++) begin
      id2 = big[i];
      step;
    end
    iv2 = 0;
    ordy2 = 1;
    for (int k = 0; k < 128; k++) begin
      for (int t = 0; t < 10 && !ov2; t++) step;
      chk("big_valid", 32'(ov2), 1);
      chk("big_a", oa2, big[br8(8'(2 * k))]);
      chk("big_b", ob2, big[br8(8'(2 * k + 1))]);
      chk("big_last", 32'(ol2), 32'(k == 127));
      step;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
